// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Multi-channel debouncer for mechanical switches. Each raw pin is brought into
// the clk_125 domain through a two-flop synchronizer. A per-channel counter then
// measures how long the synchronized level has disagreed with the accepted
// (debounced) level. The new level is accepted only after DEBOUNCE_COUNT
// consecutive disagreeing cycles. Any cycle of agreement, such as a bounce
// back to the old level, restarts the window.
//
// A clean, held change on sw_raw[i] appears on sw_db[i] exactly
// 2 + DEBOUNCE_COUNT clock edges later. The 2 edges are the synchronizer
// delay, and the remaining edges are the stability window.
//
// Optional feature, selected by the macro SW_EDGE_DETECT_EN:
//   defined   : sw_rise / sw_fall give one-cycle pulses. Each pulse is
//               registered on the same edge on which sw_db changes.
//   undefined : no edge logic is built, and sw_rise / sw_fall are tied to 0.
//
// Parameters
//   NUM_SW          number of independent switch channels (1..8)
//   DEBOUNCE_COUNT  consecutive stable cycles needed to accept a new level
//                   (2 .. 2^24-1; the default is 10 ms at 125 MHz)
//
// Ports
//   clk_125  in   sole clock, 125 MHz
//   reset_n  in   asynchronous active-low reset. Release must already be
//                 synchronous to clk_125.
//   sw_raw   in   raw switch pins; asynchronous to clk_125 and may bounce
//   sw_db    out  registered debounced level per channel
//   sw_rise  out  one-cycle pulse when a 0->1 change is accepted
//   sw_fall  out  one-cycle pulse when a 1->0 change is accepted
// -----------------------------------------------------------------------------
module switch_debounce #(
   parameter int NUM_SW         = 4,
   parameter int DEBOUNCE_COUNT = 1250000
) (
   input  logic              clk_125,
   input  logic              reset_n,
   input  logic [NUM_SW-1:0] sw_raw,
   output logic [NUM_SW-1:0] sw_db,
   output logic [NUM_SW-1:0] sw_rise,
   output logic [NUM_SW-1:0] sw_fall
);

   // The counter is wide enough to hold DEBOUNCE_COUNT. It only ever reaches
   // DEBOUNCE_COUNT-1, because the accepting cycle clears it instead of
   // incrementing it, so it can never wrap.
   localparam int               CNT_W    = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

   // Two-flop synchronizer. sync2_reg is the synchronized level s[i] that is
   // used by the debounce logic.
   logic [NUM_SW-1:0] sync1_reg;
   logic [NUM_SW-1:0] sync2_reg;

   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= sw_raw;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SW; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             db_reg;
         logic             db_next;
         logic             differs;
         logic             accept;

         assign differs = (sync2_reg[gi] != db_reg);
         // The last cycle of a full disagreeing window accepts the new level.
         assign accept  = differs && (cnt_reg == CNT_LAST);

         always_comb begin
            cnt_next = '0;
            db_next  = db_reg;
            if (accept) begin
               db_next = sync2_reg[gi];
            end else if (differs) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         always_ff @(posedge clk_125 or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg <= '0;
               db_reg  <= 1'b0;
            end else begin
               cnt_reg <= cnt_next;
               db_reg  <= db_next;
            end
         end

         assign sw_db[gi] = db_reg;

`ifdef SW_EDGE_DETECT_EN
         // These pulses are registered alongside db_reg, so each pulse lines up
         // with the sw_db change. Rise and fall cannot both be set, because
         // accept selects exactly one direction.
         logic rise_reg;
         logic fall_reg;

         always_ff @(posedge clk_125 or negedge reset_n) begin
            if (!reset_n) begin
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
            end else begin
               rise_reg <= accept & sync2_reg[gi];
               fall_reg <= accept & ~sync2_reg[gi];
            end
         end

         assign sw_rise[gi] = rise_reg;
         assign sw_fall[gi] = fall_reg;
`else
         assign sw_rise[gi] = 1'b0;
         assign sw_fall[gi] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Testbench for switch_debounce with NUM_SW=4 and DEBOUNCE_COUNT=8. The edge
// pulse expectations follow SW_EDGE_DETECT_EN: when the macro is undefined,
// the pulses are expected to stay at 0.
//
// The reference model describes behaviour, not structure. The level s seen by
// the debouncer at edge k is the raw input that was sampled two edges earlier.
// A channel flips at edge k when the last DEBOUNCE_COUNT such levels all
// differ from the current accepted level.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

   localparam int NUM_SW = 4;
   localparam int D      = 8;
   localparam int W3     = 3 * NUM_SW;

`ifdef SW_EDGE_DETECT_EN
   localparam logic [NUM_SW-1:0] EMASK = '1;
`else
   localparam logic [NUM_SW-1:0] EMASK = '0;
`endif

   logic              clk_125;
   logic              reset_n;
   logic [NUM_SW-1:0] sw_raw;
   logic [NUM_SW-1:0] sw_db;
   logic [NUM_SW-1:0] sw_rise;
   logic [NUM_SW-1:0] sw_fall;

   int n_vec = 0;
   int n_err = 0;

   switch_debounce #(
      .NUM_SW         (NUM_SW),
      .DEBOUNCE_COUNT (D)
   ) dut (
      .clk_125 (clk_125),
      .reset_n (reset_n),
      .sw_raw  (sw_raw),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
   );

   initial clk_125 = 1'b0;
   always #4 clk_125 = ~clk_125;

   // ---------------- reference model ----------------
   // hist[0] holds the raw value sampled at the previous edge. hist[1..D] are
   // the D levels presented to the debouncer at the current edge and the
   // D-1 edges before it.
   logic [NUM_SW-1:0] hist [0:D];
   logic [NUM_SW-1:0] m_db;
   logic [NUM_SW-1:0] m_rise;
   logic [NUM_SW-1:0] m_fall;

   function automatic logic [NUM_SW-1:0] settled(input logic [NUM_SW-1:0] db);
      logic [NUM_SW-1:0] m;
      m = '1;
      for (int j = 1; j <= D; j++) m &= (hist[j] ^ db);
      return m;
   endfunction

   always @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j <= D; j++) hist[j] <= '0;
         m_db   <= '0;
         m_rise <= '0;
         m_fall <= '0;
      end else begin
         m_db   <= m_db ^ settled(m_db);
         m_rise <= settled(m_db) & ~m_db & EMASK;
         m_fall <= settled(m_db) & m_db & EMASK;
         hist[0] <= sw_raw;
         for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [W3-1:0] act,
                        input logic [W3-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one clock edge. Outputs are sampled on the falling edge and checked
   // against the model.
   task automatic tick();
      @(posedge clk_125);
      @(negedge clk_125);
      check("model", {sw_db, sw_rise, sw_fall}, {m_db, m_rise, m_fall});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic              rst_n;
      logic [NUM_SW-1:0] raw;
      logic [NUM_SW-1:0] db;
      logic [NUM_SW-1:0] rise;
      logic [NUM_SW-1:0] fall;
   } vec_t;

   vec_t tbl [14];

   initial begin
      // Reset held with all switches high, then released. The result is
      // expected on edge 10.
      tbl[0] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
      tbl[1] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0};
      for (int i = 2; i <= 10; i++) tbl[i] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0};
      tbl[11] = '{1'b1, 4'hF, 4'hF, 4'hF, 4'h0};
      tbl[12] = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0};
      tbl[13] = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0};

      reset_n = 1'b0;
      sw_raw  = 4'hF;
      @(negedge clk_125);

      // ---- table: reset state and release with all switches held high ----
      for (int i = 0; i < 14; i++) begin
         reset_n = tbl[i].rst_n;
         sw_raw  = tbl[i].raw;
         tick();
         check($sformatf("table[%0d]", i), {sw_db, sw_rise, sw_fall},
               {tbl[i].db, tbl[i].rise & EMASK, tbl[i].fall & EMASK});
      end

      // ---- bouncing input on channel 0, then a steady high ----
      sw_raw = '0;
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      for (int t = 0; t < 60; t++) begin
         sw_raw[0] = ((t / 3) % 2 == 0);
         tick();
         check("bounce_quiet", W3'({sw_db[0], sw_rise[0]}), '0);
      end
      sw_raw[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check($sformatf("bounce_hold_e%0d", k), W3'({sw_db[0], sw_rise[0]}),
               W3'({(k >= 10), ((k == 10) & EMASK[0])}));
      end

      // ---- a 7-cycle low glitch on channel 2 while it is high ----
      sw_raw = 4'b0101;
      for (int i = 0; i < 12; i++) tick();
      check("glitch_setup", W3'(sw_db), W3'(4'b0101));
      sw_raw[2] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("glitch_low", W3'({sw_db[2], sw_fall[2]}), W3'(2'b10));
      end
      sw_raw[2] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("glitch_after", W3'({sw_db[2], sw_fall[2]}), W3'(2'b10));
      end

      // ---- simultaneous rise on channel 1 and fall on channel 3 ----
      sw_raw = 4'b1101;
      for (int i = 0; i < 12; i++) tick();
      check("coinc_setup", W3'(sw_db), W3'(4'b1101));
      sw_raw = 4'b0111;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check($sformatf("coinc_e%0d", k), {sw_db, sw_rise, sw_fall},
               {(k >= 10) ? 4'b0111 : 4'b1101,
                (k == 10) ? (4'b0010 & EMASK) : 4'b0000,
                (k == 10) ? (4'b1000 & EMASK) : 4'b0000});
      end

      // ---- reset pulse partway through a 0->1 window on channel 0 ----
      sw_raw = '0;
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      sw_raw[0] = 1'b1;
      for (int i = 0; i < 7; i++) tick();   // counter now at 5
      reset_n = 1'b0;
      tick();
      check("midreset_low", {sw_db, sw_rise, sw_fall}, '0);
      tick();
      reset_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check($sformatf("midreset_e%0d", k), {sw_db, sw_rise, sw_fall},
               {(k >= 10) ? 4'b0001 : 4'b0000,
                (k == 10) ? (4'b0001 & EMASK) : 4'b0000, 4'b0000});
      end

      // ---- randomized bouncing and occasional resets ----
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NUM_SW; b++)
            if ($urandom_range(0, 11) == 0) sw_raw[b] = ~sw_raw[b];
         reset_n = ($urandom_range(0, 499) != 0);
         tick();
      end
      reset_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
